// File: rtl/bitonic_pkg.sv
// Shared types for the bitonic merge datapath: element/vector payloads,
// padding sentinel and the packer fill-state enum.
package bitonic_pkg;

  localparam int unsigned STREAM_WIDTH     = 8;
  localparam int unsigned LOG_STREAM_WIDTH = $clog2(STREAM_WIDTH);
  localparam int unsigned BITS_ROW_IDX     = 16;
  localparam int unsigned DATA_PRECISION   = 16;
  localparam int unsigned DATA_WIDTH       = BITS_ROW_IDX + DATA_PRECISION;
  localparam int unsigned CNT_WIDTH        = LOG_STREAM_WIDTH + 1;

  // row_idx sits in the MSBs so the sort network can compare on it directly
  typedef struct packed {
    logic [BITS_ROW_IDX-1:0]   row_idx;
    logic [DATA_PRECISION-1:0] value;
  } elem_t;

  typedef elem_t [STREAM_WIDTH-1:0] vec_t;

  // Padding element: largest row index so pads sort to the top of a vector
  localparam elem_t SENTINEL = '{row_idx: '1, value: '0};

  typedef enum logic {
    FILL   = 1'b0,
    CLOSED = 1'b1
  } state_t;

endpackage

// File: rtl/bitonic_stream_packer_if.sv
// Element-in / vector-out handshake bundle of the stream packer.
//   in_*  : serial {row_idx, value} elements, valid/ready, in_last closes a vector
//   out_* : packed vector, element count and last flag, valid/ready
// slave modport is the packer side, master modport the surrounding logic.
interface bitonic_stream_packer_if;
  import bitonic_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  elem_t                in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  vec_t                 out_data;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_last
  );

endinterface

// File: rtl/bitonic_stream_packer.sv
// Packs a serial element stream into STREAM_WIDTH-wide vectors in arrival
// order, padding short vectors with SENTINEL, for the bitonic sort network.
// Ports:
//   clk   - clock
//   rst_b - asynchronous active-low reset
//   bus   - slave side of bitonic_stream_packer_if (element in, vector out)
module bitonic_stream_packer
  import bitonic_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_b,
  bitonic_stream_packer_if.slave   bus
);

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [LOG_STREAM_WIDTH-1:0]  r_wr_idx;
  vec_t                         r_buf;
  logic [CNT_WIDTH-1:0]         r_hold_cnt;
  logic                         r_hold_last;
  logic                         r_out_valid;
  vec_t                         r_out_data;
  logic [CNT_WIDTH-1:0]         r_out_cnt;
  logic                         r_out_last;

  logic                         w_accept;
  logic                         w_close;
  logic                         w_load_ok;
  logic                         w_load;
  vec_t                         w_close_vec;
  logic [CNT_WIDTH-1:0]         w_close_cnt;
  vec_t                         w_ld_vec;
  logic [CNT_WIDTH-1:0]         w_ld_cnt;
  logic                         w_ld_last;

  assign w_accept    = bus.in_valid && (r_state == FILL);
  assign w_close     = w_accept &&
                       ((r_wr_idx == LOG_STREAM_WIDTH'(STREAM_WIDTH - 1)) || bus.in_last);
  assign w_load_ok   = !r_out_valid || bus.out_ready;
  assign w_close_cnt = CNT_WIDTH'(r_wr_idx) + CNT_WIDTH'(1);

  // Vector as it looks on close: filled slots, the closing element, then pads
  always_comb begin
    w_close_vec = '0;
    for (int unsigned i = 0; i < STREAM_WIDTH; i++) begin
      if (LOG_STREAM_WIDTH'(i) < r_wr_idx)
        w_close_vec[i] = r_buf[i];
      else if (LOG_STREAM_WIDTH'(i) == r_wr_idx)
        w_close_vec[i] = bus.in_data;
      else
        w_close_vec[i] = SENTINEL;
    end
  end

  // A held vector in CLOSED was already padded when it was captured
  assign w_ld_vec  = (r_state == CLOSED) ? r_buf       : w_close_vec;
  assign w_ld_cnt  = (r_state == CLOSED) ? r_hold_cnt  : w_close_cnt;
  assign w_ld_last = (r_state == CLOSED) ? r_hold_last : bus.in_last;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // Next state and output-register load decision
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_close) begin
          if (w_load_ok) w_load      = 1'b1;
          else           w_state_nxt = CLOSED;
        end
      end
      CLOSED: begin
        if (w_load_ok) begin
          w_load      = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Fill buffer and output register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_idx    <= '0;
      r_buf       <= '0;
      r_hold_cnt  <= '0;
      r_hold_last <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_wr_idx <= '0;
          if (!w_load_ok) begin
            r_buf       <= w_close_vec;
            r_hold_cnt  <= w_close_cnt;
            r_hold_last <= bus.in_last;
          end
        end else begin
          r_buf[r_wr_idx] <= bus.in_data;
          r_wr_idx        <= r_wr_idx + LOG_STREAM_WIDTH'(1);
        end
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ld_vec;
        r_out_cnt   <= w_ld_cnt;
        r_out_last  <= w_ld_last;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (r_state == FILL);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_bitonic_stream_packer.sv
// Scoreboard bench for bitonic_stream_packer: a stream model pushes expected
// vectors as elements are accepted; a monitor pops them on each output handshake.
module tb_bitonic_stream_packer;
  import bitonic_pkg::*;

  localparam int unsigned VW = $bits(vec_t);

  typedef struct {
    vec_t                 data;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 last;
  } exp_t;

  logic clk;
  logic rst_b;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   n_push;
  int   n_pop;
  int   n_flushed;
  int   rdy_drops;
  bit   track_rdy;

  exp_t  sb[$];
  int    pop_cyc[$];
  elem_t m_buf[STREAM_WIDTH];
  int    m_n;

  bitonic_stream_packer_if bus();

  bitonic_stream_packer dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference stream model: collects accepted elements, emits padded vectors
  task automatic model_accept(input elem_t e, input logic last);
    exp_t x;
    m_buf[m_n] = e;
    m_n++;
    if (m_n == STREAM_WIDTH || last) begin
      for (int k = 0; k < STREAM_WIDTH; k++)
        x.data[k] = (k < m_n) ? m_buf[k] : elem_t'(32'hFFFF_0000);
      x.cnt  = CNT_WIDTH'(m_n);
      x.last = last;
      sb.push_back(x);
      n_push++;
      m_n = 0;
    end
  endtask

  // Drive one element and wait (bounded) for it to be accepted
  task automatic send(input logic [15:0] row, input logic [15:0] val, input logic last);
    bit ok;
    elem_t e;
    e = '{row_idx: row, value: val};
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = e;
    bus.in_last  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      if (ok) break;
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (ok) model_accept(e, last);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept of row %0h", row);
    end
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_empty", VW'(sb.size()), VW'(0));
  endtask

  // Output monitor / scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (rst_b && bus.out_valid && bus.out_ready) begin
      pop_cyc.push_back(cyc);
      n_pop++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_vector: got cnt=%0d expected no vector", bus.out_cnt);
      end else begin
        e = sb.pop_front();
        check("out_data", VW'(bus.out_data), VW'(e.data));
        check("out_cnt",  VW'(bus.out_cnt),  VW'(e.cnt));
        check("out_last", VW'(bus.out_last), VW'(e.last));
      end
    end
    if (track_rdy && rst_b && !bus.in_ready) rdy_drops++;
  end

  initial begin
    vec_t snap;
    n_checks = 0; n_fail = 0; n_push = 0; n_pop = 0; n_flushed = 0;
    rdy_drops = 0; track_rdy = 1'b0; m_n = 0; cyc = 0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", VW'(bus.out_valid), VW'(0));
    check("rst_out_cnt",   VW'(bus.out_cnt),   VW'(0));
    check("rst_out_last",  VW'(bus.out_last),  VW'(0));
    check("rst_out_data",  VW'(bus.out_data),  VW'(0));
    check("rst_in_ready",  VW'(bus.in_ready),  VW'(1));
    rst_b = 1'b1;
    @(posedge clk); #1;

    // 1: full vector, latency and continuous in_ready
    begin
      logic [15:0] rows [8];
      rows = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd7, 16'd2, 16'd8, 16'd4};
      rdy_drops = 0; track_rdy = 1'b1;
      for (int k = 0; k < 7; k++) send(rows[k], 16'h0100 + 16'(k), 1'b0);
      check("t1_valid_before", VW'(bus.out_valid), VW'(0));
      send(rows[7], 16'h0107, 1'b0);
      check("t1_valid_after", VW'(bus.out_valid), VW'(1));
      check("t1_slot7", VW'(bus.out_data[7]), VW'(32'h0004_0107));
      track_rdy = 1'b0;
      check("t1_in_ready_drops", VW'(rdy_drops), VW'(0));
      drain(20);
    end

    // 2: short vector closed by in_last, padded with sentinel
    send(16'd4, 16'h0201, 1'b0);
    send(16'd4, 16'h0202, 1'b0);
    send(16'd2, 16'h0203, 1'b1);
    check("t2_cnt",   VW'(bus.out_cnt),     VW'(3));
    check("t2_last",  VW'(bus.out_last),    VW'(1));
    check("t2_slot2", VW'(bus.out_data[2]), VW'(32'h0002_0203));
    check("t2_slot3", VW'(bus.out_data[3]), VW'(32'hFFFF_0000));
    check("t2_slot7", VW'(bus.out_data[7]), VW'(32'hFFFF_0000));
    drain(20);

    // 3: backpressure, held vector and CLOSED state
    bus.out_ready = 1'b0;
    for (int j = 0; j < 16; j++) send(16'h0030 + 16'(j), 16'(j), 1'b0);
    check("t3_in_ready_low", VW'(bus.in_ready), VW'(0));
    check("t3_held_valid",   VW'(bus.out_valid), VW'(1));
    snap = sb[0].data;
    repeat (3) @(posedge clk);
    #1;
    check("t3_held_data",    VW'(bus.out_data), VW'(snap));
    check("t3_held_cnt",     VW'(bus.out_cnt),  VW'(8));
    check("t3_held_slot0",   VW'(bus.out_data[0]), VW'(32'h0030_0000));
    check("t3_still_closed", VW'(bus.in_ready), VW'(0));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("t3_second_valid", VW'(bus.out_valid),  VW'(1));
    check("t3_second_slot0", VW'(bus.out_data[0]), VW'(32'h0038_0008));
    check("t3_in_ready_back", VW'(bus.in_ready),  VW'(1));
    bus.out_ready = 1'b1;
    drain(20);

    // 4: 64 continuous elements, 8 vectors spaced 8 cycles apart
    pop_cyc.delete();
    rdy_drops = 0; track_rdy = 1'b1;
    for (int i = 0; i < 64; i++) send(16'(i), 16'h1000 + 16'(i), 1'b0);
    drain(20);
    track_rdy = 1'b0;
    check("t4_in_ready_drops", VW'(rdy_drops), VW'(0));
    check("t4_n_vectors", VW'(pop_cyc.size()), VW'(8));
    if (pop_cyc.size() == 8)
      for (int v = 1; v < 8; v++)
        check("t4_spacing", VW'(pop_cyc[v] - pop_cyc[v-1]), VW'(8));

    // 5: async reset with a held vector and a partial fill
    bus.out_ready = 1'b0;
    for (int j = 0; j < 13; j++) send(16'h0040 + 16'(j), 16'(j), 1'b0);
    rst_b = 1'b0;
    n_flushed += sb.size();
    sb.delete();
    m_n = 0;
    #1;
    check("t5_rst_valid",    VW'(bus.out_valid), VW'(0));
    check("t5_rst_cnt",      VW'(bus.out_cnt),   VW'(0));
    check("t5_rst_in_ready", VW'(bus.in_ready),  VW'(1));
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) send(16'h0050 + 16'(j), 16'h0500 + 16'(j), 1'b0);
    check("t5_slot0", VW'(bus.out_data[0]), VW'(32'h0050_0500));
    drain(20);

    // 6: in_last on slot 7 then a 2-element stream
    for (int j = 0; j < 8; j++) send(16'h0060 + 16'(j), 16'(j), (j == 7));
    check("t6a_cnt",  VW'(bus.out_cnt),  VW'(8));
    check("t6a_last", VW'(bus.out_last), VW'(1));
    send(16'h0070, 16'h0001, 1'b0);
    send(16'h0071, 16'h0002, 1'b1);
    check("t6b_cnt",  VW'(bus.out_cnt),  VW'(2));
    check("t6b_last", VW'(bus.out_last), VW'(1));
    drain(20);

    // No trailing or spurious vectors
    repeat (20) @(posedge clk);
    #1;
    check("idle_out_valid", VW'(bus.out_valid), VW'(0));
    check("pop_vs_push",    VW'(n_pop),         VW'(n_push - n_flushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitonic_stream_packer.md
Name: bitonic_stream_packer

Overview:
Upstream feeder for the bitonic sort network in the SpMV merge datapath. It accepts a serial stream of {row_idx, value} elements over a valid/ready handshake. It packs them into STREAM_WIDTH-wide vectors in arrival order and pads short vectors with a sentinel. Each completed vector is presented downstream with valid/ready, element count and last flag. Slot order equals arrival order, so the sort network's stream-id tie-break preserves arrival order for equal row indices.

Parameters:
STREAM_WIDTH, `STREAM_WIDTH, elements per packed vector (power of 2, >=2)
LOG_STREAM_WIDTH, `LOG_STREAM_WIDTH, log2(STREAM_WIDTH)
BITS_ROW_IDX, `BITS_ROW_IDX, row index width
DATA_PRECISION, `DATA_PRECISION, value width
DATA_WIDTH, BITS_ROW_IDX + DATA_PRECISION, element width; row_idx occupies the MSBs

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
in_valid  input  1  element valid
in_ready  output  1  element accepted when in_valid && in_ready
in_data  input  DATA_WIDTH  element {row_idx, value}
in_last  input  1  final element of the current stream; closes the vector
out_valid  output  1  packed vector valid
out_ready  input  1  downstream accepts the vector
out_data  output  [STREAM_WIDTH][DATA_WIDTH]  packed vector; slot i holds the i-th arrival
out_cnt  output  LOG_STREAM_WIDTH+1  number of real elements, range 1..STREAM_WIDTH
out_last  output  1  vector contains the stream's last element

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_b.
- Reset values: out_valid=0, out_data=0, out_cnt=0, out_last=0, fill index wr_idx=0, state=FILL, so in_ready=1.
- Storage: a fill buffer of STREAM_WIDTH slots plus an output register. There is no further queueing.
- State FILL: in_ready=1. On each accept, in_data is written to slot wr_idx and wr_idx increments.
- A vector closes on an accept when wr_idx==STREAM_WIDTH-1 or in_last=1.
- On close, slots above the final wr_idx are padded with SENTINEL = {all-ones row_idx, zero value}. Padded entries therefore sort to the top.
- Closed-vector count = final wr_idx+1. Closed-vector last flag = in_last.
- Output register load condition: load_ok = !out_valid || out_ready.
- Close with load_ok true in the same cycle: the vector, count and last load into the output register on the next edge. out_valid=1 one cycle after the closing accept, wr_idx returns to 0 and the state stays FILL.
- Close with load_ok false: the state moves to CLOSED. in_ready=0 and the fill buffer holds its contents.
- State CLOSED: on the first cycle load_ok is true, the held vector loads into the output register, wr_idx=0 and the state returns to FILL. in_ready is 1 in the following cycle.
- Output hold: out_valid stays 1 with out_data, out_cnt and out_last stable until out_ready=1. It then drops unless a new vector loads on the same edge.
- Back-to-back vectors are allowed. A drain and a load on the same edge produce continuous out_valid with no bubble.
- Throughput: one element per cycle sustained when out_ready=1. in_ready never deasserts in that case.
- in_last on slot STREAM_WIDTH-1 produces exactly one vector with cnt=STREAM_WIDTH and last=1. No empty trailing vector is emitted.
- An empty vector is never emitted, because every close is caused by an accepted element.
- rst_b asserted mid-fill or mid-hold discards all partial and held data immediately, since reset is asynchronous.
- in_data is not inspected: the block performs no ordering and no row-index checks.

Decomposition:
- Shared package bitonic_pkg holds elem_t (DATA_WIDTH packed struct {row_idx, value}) and vec_t (STREAM_WIDTH × elem_t).
- bitonic_pkg also holds the SENTINEL constant and the FILL/CLOSED state enum. The sort network reuses elem_t and vec_t.
- Single module; no sub-module is warranted.

Test Plan:
1. STREAM_WIDTH=8, out_ready=1; feed rows 5,3,9,1,7,2,8,4 back-to-back -> out_valid exactly 1 cycle after the 8th accept; out_data[0..7]=those elements in order; out_cnt=8, out_last=0; in_ready stays 1.
2. Feed 3 elements (rows 4,4,2) with in_last on the 3rd -> out_cnt=3, out_last=1; slots 0-2 = inputs in order; slots 3-7 = {row_idx all-ones, value 0}.
3. out_ready=0; fill two vectors -> first is held stable; in_ready drops the cycle after the 16th accept. Pulse out_ready for 1 cycle -> second vector appears the next cycle and in_ready returns to 1. All 16 elements are seen exactly once.
4. 64 continuous elements, out_ready=1 -> 8 vectors spaced 8 cycles apart; in_ready never 0; slot k of vector v equals element 8v+k.
5. Assert rst_b low after 5 accepts and with a held vector pending -> out_valid=0 and out_cnt=0 immediately. The next 8 elements after release form a vector starting at slot 0 with no stale data.
6. in_last on the 8th element, then a new stream of 2 with in_last -> vector A has cnt=8, last=1; vector B has cnt=2, last=1. No extra vector is emitted.
